vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have the parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have the parameter H_FRONT, default 16, meaning front porch length in pixel clocks.
REQ-003 The block SHALL have the parameter H_SYNC, default 96, meaning horizontal sync pulse length in pixel clocks.
REQ-004 The block SHALL have the parameter H_BACK, default 48, meaning back porch length in pixel clocks.
REQ-005 The block SHALL have the parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have the parameter V_FRONT, default 10, meaning front porch length in lines.
REQ-007 The block SHALL have the parameter V_SYNC, default 2, meaning vertical sync pulse length in lines.
REQ-008 The block SHALL have the parameter V_BACK, default 33, meaning back porch length in lines.
REQ-009 The block SHALL have the parameter SYNC_POL, default 0, meaning sync active level (0 = active-low).
REQ-010 The block SHALL have the port CLK, input, 1 bit: pixel clock, 25 MHz from the video PLL global output.
REQ-011 The block SHALL have the port RESET, input, 1 bit: synchronous, active-high reset. One clock; reset is synchronous and active-high.
REQ-012 The block SHALL have the port ENABLE, input, 1 bit: when high, the raster advances one pixel per clock.
REQ-013 The block SHALL have the port HSYNC, output, 1 bit: horizontal sync.
REQ-014 The block SHALL have the port VSYNC, output, 1 bit: vertical sync.
REQ-015 The block SHALL have the port DE, output, 1 bit: display enable, high inside the active area.
REQ-016 The block SHALL have the port PIXEL_X, output, 10 bits: current horizontal position.
REQ-017 The block SHALL have the port PIXEL_Y, output, 10 bits: current vertical position.
REQ-018 The block SHALL have the port LINE_START, output, 1 bit: one-cycle pulse at X=0 of every line.
REQ-019 The block SHALL have the port FRAME_START, output, 1 bit: one-cycle pulse at X=0, Y=0.

Function
REQ-020 The block SHALL define H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800) and V_TOTAL as the corresponding vertical sum (default 525); both SHALL be at most 1024.
REQ-021 The internal 10-bit counters hcnt and vcnt SHALL increment hcnt on each clock with ENABLE=1 and wrap hcnt from H_TOTAL-1 to 0.
REQ-022 vcnt SHALL increment only on an hcnt wrap and SHALL wrap from V_TOTAL-1 to 0 on the same clock that hcnt wraps.
REQ-023 When ENABLE=0, the counters and all outputs SHALL hold their values, and any asserted pulse SHALL stay asserted.
REQ-024 Decode SHALL set DE = (hcnt<H_ACTIVE) and (vcnt<V_ACTIVE).
REQ-025 Decode SHALL assert the horizontal sync for H_ACTIVE+H_FRONT <= hcnt < H_ACTIVE+H_FRONT+H_SYNC (656..751).
REQ-026 Decode SHALL assert the vertical sync for V_ACTIVE+V_FRONT <= vcnt < V_ACTIVE+V_FRONT+V_SYNC (490..491), spanning whole lines.
REQ-027 The sync output level SHALL be SYNC_POL when active and ~SYNC_POL when inactive.
REQ-028 All outputs SHALL be registered with one pipeline stage, so that they reflect the counter value of the previous enabled clock; PIXEL_X and PIXEL_Y SHALL equal the hcnt and vcnt of that same stage, so that all outputs remain mutually aligned.
REQ-029 PIXEL_X and PIXEL_Y SHALL count through the blanking regions, so they are not clamped to the active area.
REQ-030 LINE_START SHALL be asserted when the registered X is 0, and FRAME_START when X=0 and Y=0.

Reset
REQ-031 While RESET=1, on each clock the block SHALL set hcnt=0, vcnt=0, PIXEL_X=0, PIXEL_Y=0, DE=0, LINE_START=0, FRAME_START=0, and HSYNC=VSYNC=~SYNC_POL.
REQ-032 RESET SHALL take priority over ENABLE.
REQ-033 A reset asserted mid-frame SHALL abort the frame with no partial pulses on the following clock.
REQ-034 On the first enabled clock after reset release, the counters SHALL advance to (1,0) and the outputs SHALL present (X=0, Y=0, DE=1, LINE_START=1, FRAME_START=1).

Verification
REQ-035 Verification SHALL cover reset release with ENABLE=1: on the 1st clock X=0, Y=0, DE=1 and FRAME_START=1; on the 2nd clock X=1 and FRAME_START=0.
REQ-036 Verification SHALL cover a full line: DE is high for 640 clocks and low for 160; HSYNC is low for exactly 96 clocks beginning at X=656; LINE_START pulses every 800 clocks.
REQ-037 Verification SHALL cover a full frame (420000 clocks): FRAME_START pulses once; VSYNC is low for exactly 1600 clocks beginning at X=0, Y=490; Y wraps 524 -> 0 as X wraps 799 -> 0.
REQ-038 Verification SHALL cover ENABLE held low for 5 clocks at X=799, Y=524: all outputs are frozen, and after re-enable the next output is X=0, Y=0 with FRAME_START=1.
REQ-039 Verification SHALL cover RESET pulsed for 1 clock at X=700, Y=200: on the next clock the outputs are at reset values; the sequence then restarts as in REQ-035.
REQ-040 Verification SHALL cover SYNC_POL=1 with all timing unchanged: HSYNC and VSYNC idle low and pulse high.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters decoded into sync, DE and start pulses.
// Latency: every output is registered once and reflects the counter value of the previous enabled clock.
// Backpressure: ENABLE low freezes the counters and every output, including any pulse already asserted.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic [9:0] PIXEL_X,
    output logic [9:0] PIXEL_Y,
    output logic       LINE_START,
    output logic       FRAME_START
);

    // Totals must not exceed 1024 so the last position fits the 10-bit counters.
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits wide so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic [9:0] r_pixel_x;
    logic [9:0] r_pixel_y;
    logic       r_line_start;
    logic       r_frame_start;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_de;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_line_start;
    logic       w_frame_start;
    logic [10:0] w_hcnt_x;
    logic [10:0] w_vcnt_x;

    // Decode the current counter position into next-cycle output values.
    always_comb begin
        w_hcnt_x      = {1'b0, r_hcnt};
        w_vcnt_x      = {1'b0, r_vcnt};
        w_h_last      = (r_hcnt == H_LAST);
        w_v_last      = (r_vcnt == V_LAST);
        w_de          = (w_hcnt_x < H_ACT_END) && (w_vcnt_x < V_ACT_END);
        w_hsync       = ((w_hcnt_x >= HS_BEG) && (w_hcnt_x < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
        w_vsync       = ((w_vcnt_x >= VS_BEG) && (w_vcnt_x < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        w_line_start  = (r_hcnt == 10'd0);
        w_frame_start = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    end

    // Raster counters: X advances per enabled clock, Y advances when X wraps, both wrap together at frame end.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (ENABLE) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? 10'd0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    // Output stage: captures the decode of the same counter value that PIXEL_X/PIXEL_Y report.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hsync       <= ~SYNC_ACT;
            r_vsync       <= ~SYNC_ACT;
            r_de          <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ENABLE) begin
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_de          <= w_de;
            r_pixel_x     <= r_hcnt;
            r_pixel_y     <= r_vcnt;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign DE          = r_de;
    assign PIXEL_X     = r_pixel_x;
    assign PIXEL_Y     = r_pixel_y;
    assign LINE_START  = r_line_start;
    assign FRAME_START = r_frame_start;

endmodule
